pci_target_addr_dec: RTL and testbench
======================================

// Module: pci_target_addr_dec
// PURPOSE
//  Upstream of the PCI target FSM. Captures the address phase: latches AD/C_BE#, decodes
//  the command, and produces card_hit, acc_rd and acc_wr for the FSM.
//  Owns the burst address counter that the FSM advances with inc_adr.
//  Raises a disconnect request at the end of the BAR window and on unsupported burst order.
// PARAMETERS
//  BAR_LSB   24   lowest decoded BAR bit; the window is 2**BAR_LSB bytes
//  ADR_W     24   local byte-address width (= BAR_LSB); the counter is bits [ADR_W-1:2]
// PORTS
//  clk        in   1            PCI clock
//  rst        in   1            reset, synchronous, active-low
//  ad_i       in   32           AD bus, sampled
//  cbe_ni     in   4            C/BE# bus, sampled
//  frameni    in   1            FRAME#, sampled
//  framenid   in   1            frameni delayed one clock
//  idseli     in   1            IDSEL, sampled
//  bar_base   in   32-BAR_LSB   BAR0 base (config-space register)
//  mem_en     in   1            command-register memory-space enable
//  inc_adr    in   1            FSM: advance to next dword
//  acc_end    in   1            FSM: turnaround state, access finished
//  card_hit   out  1            memory or config hit, valid the cycle after the address phase
//  cfg_hit    out  1            config type-0 hit
//  acc_rd     out  1            latched command is a read
//  acc_wr     out  1            latched command is a write
//  t_cmd      out  4            latched command
//  t_adr      out  ADR_W-2      current dword address
//  t_term_req out  1            disconnect request (goes to the FSM t_term)
// BEHAVIOUR
//  - Address phase (adr_ph) = frameni==0 & framenid==1. All latches load on that edge only.
//  - Reset (rst==0 at clk edge): all outputs 0, t_cmd=0, counter 0. Reset mid-burst aborts
//    immediately. No state survives reset.
//  - Command decode, C/BE# inverted:
//      MRD 0110, MRM 1100, MRL 1110 -> read
//      MWR 0111, MWI 1111           -> write
//      CRD 1010 -> read;  CWR 1011 -> write
//      All other codes: no hit. acc_rd=acc_wr=0.
//  - Memory hit: memory command & mem_en & ad_i[31:BAR_LSB]==bar_base.
//  - Config hit: CRD/CWR & idseli & ad_i[1:0]==2'b00.
//  - card_hit = registered (mem hit | cfg hit). Exactly 1 clock latency after adr_ph, so the
//    FSM sees it in its decode state.
//  - Clearing: card_hit, cfg_hit, acc_rd and acc_wr clear on the edge where acc_end==1.
//    If adr_ph and acc_end occur together (fast back-to-back), the new decode wins.
//  - No-hit address phase: outputs are written to 0 on that edge; the earlier access is
//    already ended by then.
//  - Counter: loads ad_i[ADR_W-1:2] at adr_ph.
//      inc_adr==1 & card_hit==1: counter +1, modulo 2**(ADR_W-2); wrap to 0 is allowed.
//      inc_adr and adr_ph together: the load wins.
//      Config access: counter holds [7:2], upper bits 0. inc_adr still increments; the FSM
//      disconnects config bursts.
//  - t_term_req (combinational from registers), asserted while card_hit is high and any of:
//      (a) memory hit and counter == all-ones (last dword of window). Disconnect, never
//          wrap into the next window.
//      (b) memory hit and latched ad[1:0]!=00 (reserved/cacheline-toggle ordering). First
//          data phase completes, then disconnect.
//      (c) cfg_hit. Single data phase only.
//    t_term_req drops with card_hit.
//  - bar_base and mem_en are sampled only at adr_ph. Changes mid-burst have no effect.
// STRUCTURE
//  - Shared package pci_defs: 4-bit command localparams (CMD_MRD, CMD_MWR, CMD_CRD, CMD_CWR,
//    CMD_MRM, CMD_MRL, CMD_MWI) and the BAR_LSB default.
//  - One sub-module, pci_cmd_decode: combinational cmd -> {is_mem, is_cfg, is_rd, is_wr}.
//    Shared with the master side.
//  - Registers: cmd, ad[1:0] order, hit flags, counter. No other state.
// TESTING
//  1. bar_base=8'h12, mem_en=1, adr_ph with AD=32'h1200_0010, C/BE#=4'b1001 (MRD)
//     -> next clk: card_hit=1, acc_rd=1, t_adr=22'h4.
//  2. Same address with AD=32'h1300_0010 or mem_en=0 -> card_hit stays 0, acc_rd=acc_wr=0.
//  3. MWR at 32'h12FF_FFF8, then inc_adr pulses -> t_adr 3FFFFE to 3FFFFF; t_term_req=1 at
//     3FFFFF. A further inc_adr wraps to 0.
//  4. idseli=1, C/BE#=4'b0101 (CRD), AD=32'h0000_0004 -> cfg_hit=1, card_hit=1,
//     t_term_req=1. Same with AD[1:0]=01 -> no hit.
//  5. acc_end=1 on the same edge as a new adr_ph for MWR 32'h1200_0100 -> card_hit stays 1,
//     acc_wr=1, acc_rd=0, t_adr=22'h40. acc_end alone -> all flags 0 next clk.
//  6. rst=0 for 1 clk mid-burst, inc_adr=1 -> all outputs 0 after that edge.

Source files
------------

// File: rtl/pci_defs.sv
// Shared PCI definitions: bus command codes (C/BE# already inverted) and the
// command classification returned by the command decoder.
package pci_defs;

    localparam int BAR_LSB_DEF = 24;

    localparam logic [3:0] CMD_MRD = 4'b0110;
    localparam logic [3:0] CMD_MWR = 4'b0111;
    localparam logic [3:0] CMD_CRD = 4'b1010;
    localparam logic [3:0] CMD_CWR = 4'b1011;
    localparam logic [3:0] CMD_MRM = 4'b1100;
    localparam logic [3:0] CMD_MRL = 4'b1110;
    localparam logic [3:0] CMD_MWI = 4'b1111;

    typedef struct packed {
        logic is_mem;
        logic is_cfg;
        logic is_rd;
        logic is_wr;
    } cmd_class_t;

endpackage

// File: rtl/pci_target_addr_dec_if.sv
// Address-phase bus and FSM handshake seen by the PCI target address decoder.
// The master modport drives the bus side, the slave modport is the decoder.
interface pci_target_addr_dec_if #(
    parameter int BAR_LSB = 24,
    parameter int ADR_W   = BAR_LSB
);
    logic [31:0]        ad_i;
    logic [3:0]         cbe_ni;
    logic               frameni;
    logic               framenid;
    logic               idseli;
    logic [31-BAR_LSB:0] bar_base;
    logic               mem_en;
    logic               inc_adr;
    logic               acc_end;
    logic               card_hit;
    logic               cfg_hit;
    logic               acc_rd;
    logic               acc_wr;
    logic [3:0]         t_cmd;
    logic [ADR_W-3:0]   t_adr;
    logic               t_term_req;

    modport master (
        output ad_i, cbe_ni, frameni, framenid, idseli, bar_base, mem_en, inc_adr, acc_end,
        input  card_hit, cfg_hit, acc_rd, acc_wr, t_cmd, t_adr, t_term_req
    );

    modport slave (
        input  ad_i, cbe_ni, frameni, framenid, idseli, bar_base, mem_en, inc_adr, acc_end,
        output card_hit, cfg_hit, acc_rd, acc_wr, t_cmd, t_adr, t_term_req
    );

endinterface

// File: rtl/pci_cmd_decode.sv
// Combinational PCI command classifier (address space and direction).
// Shared between the target and master sides.
module pci_cmd_decode
    import pci_defs::*;
(
    input  logic [3:0]  i_cmd,
    output cmd_class_t  o_cls
);

    // Map each supported command to {is_mem, is_cfg, is_rd, is_wr}; others classify as nothing.
    always_comb begin
        o_cls = cmd_class_t'(4'b0000);
        case (i_cmd)
            CMD_MRD, CMD_MRM, CMD_MRL: o_cls = cmd_class_t'(4'b1010);
            CMD_MWR, CMD_MWI:          o_cls = cmd_class_t'(4'b1001);
            CMD_CRD:                   o_cls = cmd_class_t'(4'b0110);
            CMD_CWR:                   o_cls = cmd_class_t'(4'b0101);
            default:                   o_cls = cmd_class_t'(4'b0000);
        endcase
    end

endmodule

// File: rtl/pci_target_addr_dec.sv
// PCI target address-phase capture: command/hit decode, burst dword counter
// and disconnect request for the target FSM.
module pci_target_addr_dec
    import pci_defs::*;
#(
    parameter int BAR_LSB = BAR_LSB_DEF,
    parameter int ADR_W   = BAR_LSB
)(
    input  logic                 clk,
    input  logic                 rst,
    pci_target_addr_dec_if.slave bus
);

    localparam int               CNT_W    = ADR_W - 2;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

    logic             w_adr_ph;
    logic [3:0]       w_cmd;
    cmd_class_t       w_cls;
    logic             w_mem_hit;
    logic             w_cfg_hit;
    logic             w_hit;
    logic [CNT_W-1:0] w_cnt_load;

    logic [3:0]       r_cmd;
    logic [1:0]       r_ord;
    logic             r_card_hit;
    logic             r_cfg_hit;
    logic             r_rd;
    logic             r_wr;
    logic [CNT_W-1:0] r_cnt;

    assign w_adr_ph = ~bus.frameni & bus.framenid;
    assign w_cmd    = ~bus.cbe_ni;

    pci_cmd_decode u_cmd_decode (
        .i_cmd (w_cmd),
        .o_cls (w_cls)
    );

    assign w_mem_hit = w_cls.is_mem & bus.mem_en & (bus.ad_i[31:BAR_LSB] == bus.bar_base);
    assign w_cfg_hit = w_cls.is_cfg & bus.idseli & (bus.ad_i[1:0] == 2'b00);
    assign w_hit     = w_mem_hit | w_cfg_hit;

    // Config accesses only address the 64-dword header, so the upper counter bits are zeroed.
    assign w_cnt_load = w_cls.is_cfg ? CNT_W'(bus.ad_i[7:2]) : bus.ad_i[ADR_W-1:2];

    // Address-phase latches, hit flags cleared at access end, and the burst counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cmd      <= 4'b0000;
            r_ord      <= 2'b00;
            r_card_hit <= 1'b0;
            r_cfg_hit  <= 1'b0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_cnt      <= {CNT_W{1'b0}};
        end else if (w_adr_ph) begin
            r_cmd      <= w_cmd;
            r_ord      <= bus.ad_i[1:0];
            r_card_hit <= w_hit;
            r_cfg_hit  <= w_cfg_hit;
            r_rd       <= w_hit & w_cls.is_rd;
            r_wr       <= w_hit & w_cls.is_wr;
            r_cnt      <= w_cnt_load;
        end else begin
            if (bus.acc_end) begin
                r_card_hit <= 1'b0;
                r_cfg_hit  <= 1'b0;
                r_rd       <= 1'b0;
                r_wr       <= 1'b0;
            end
            if (bus.inc_adr & r_card_hit) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign bus.card_hit = r_card_hit;
    assign bus.cfg_hit  = r_cfg_hit;
    assign bus.acc_rd   = r_rd;
    assign bus.acc_wr   = r_wr;
    assign bus.t_cmd    = r_cmd;
    assign bus.t_adr    = r_cnt;

    // A memory burst must stop before leaving the BAR window or on non-linear ordering.
    assign bus.t_term_req = r_card_hit & (r_cfg_hit | (r_cnt == CNT_LAST) | (r_ord != 2'b00));

endmodule

// File: tb/tb_pci_target_addr_dec.sv
// Self-checking bench for pci_target_addr_dec: directed scenarios plus random
// address phases, all checked every cycle against a behavioural model.
module tb_pci_target_addr_dec;

    localparam int          K_NONE = 0;
    localparam int          K_MRD  = 1;
    localparam int          K_MWR  = 2;
    localparam int          K_CRD  = 3;
    localparam int          K_CWR  = 4;
    localparam int unsigned WIN    = 32'd4194304;

    typedef struct packed {
        bit          hit;
        bit          cfg;
        bit          rd;
        bit          wr;
        int unsigned cmd;
        int unsigned ord;
        int unsigned adr;
    } mstate_t;

    logic    clk = 1'b0;
    logic    rst;
    int      n_chk  = 0;
    int      n_fail = 0;
    mstate_t m = '0;

    always #5 clk = ~clk;

    pci_target_addr_dec_if #(.BAR_LSB(24), .ADR_W(24)) bus ();

    pci_target_addr_dec #(.BAR_LSB(24), .ADR_W(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int kind_of(input logic [3:0] c);
        case (c)
            4'b0110, 4'b1100, 4'b1110: return K_MRD;
            4'b0111, 4'b1111:          return K_MWR;
            4'b1010:                   return K_CRD;
            4'b1011:                   return K_CWR;
            default:                   return K_NONE;
        endcase
    endfunction

    // Reference behaviour: what the registers must hold after one clock edge.
    function automatic mstate_t model_next(input mstate_t s, input logic rst_v,
                                           input logic fn, input logic fnd,
                                           input logic [31:0] ad, input logic [3:0] cbe,
                                           input logic ids, input logic [7:0] bar,
                                           input logic men, input logic inc, input logic ae);
        mstate_t     n;
        int          k;
        bit          mem_ok;
        bit          cfg_ok;
        logic [3:0]  c;
        n = s;
        if (rst_v == 1'b0) begin
            n = '0;
        end else if (!fn && fnd) begin
            c      = ~cbe;
            k      = kind_of(c);
            mem_ok = (k == K_MRD || k == K_MWR) && men && (ad[31:24] == bar);
            cfg_ok = (k == K_CRD || k == K_CWR) && ids && (ad[1:0] == 2'b00);
            n.hit  = mem_ok || cfg_ok;
            n.cfg  = cfg_ok;
            n.rd   = n.hit && (k == K_MRD || k == K_CRD);
            n.wr   = n.hit && (k == K_MWR || k == K_CWR);
            n.cmd  = 32'(c);
            n.ord  = 32'(ad[1:0]);
            if (k == K_CRD || k == K_CWR) n.adr = (32'(ad[31:2])) % 32'd64;
            else                          n.adr = (32'(ad[31:2])) % WIN;
        end else begin
            if (inc && s.hit) n.adr = (s.adr + 32'd1) % WIN;
            if (ae) begin
                n.hit = 1'b0;
                n.cfg = 1'b0;
                n.rd  = 1'b0;
                n.wr  = 1'b0;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m <= model_next(m, rst, bus.frameni, bus.framenid, bus.ad_i, bus.cbe_ni, bus.idseli,
                        bus.bar_base, bus.mem_en, bus.inc_adr, bus.acc_end);
    end

    always @(posedge clk) begin
        #1;
        cmp("card_hit",   32'(bus.card_hit),   32'(m.hit));
        cmp("cfg_hit",    32'(bus.cfg_hit),    32'(m.cfg));
        cmp("acc_rd",     32'(bus.acc_rd),     32'(m.rd));
        cmp("acc_wr",     32'(bus.acc_wr),     32'(m.wr));
        cmp("t_cmd",      32'(bus.t_cmd),      m.cmd);
        cmp("t_adr",      32'(bus.t_adr),      m.adr);
        cmp("t_term_req", 32'(bus.t_term_req),
            32'(m.hit && (m.cfg || m.adr == WIN - 32'd1 || m.ord != 32'd0)));
    end

    task automatic go(input logic fn, input logic fnd, input logic [31:0] ad,
                      input logic [3:0] cbe, input logic inc, input logic ae);
        @(negedge clk);
        bus.frameni  = fn;
        bus.framenid = fnd;
        bus.ad_i     = ad;
        bus.cbe_ni   = cbe;
        bus.inc_adr  = inc;
        bus.acc_end  = ae;
    endtask

    logic [3:0]  vcmd [7];
    logic [31:0] r_ad;
    logic [3:0]  r_cbe;
    logic        r_fn;
    logic        prev_fn;

    initial begin
        vcmd = '{4'b0110, 4'b0111, 4'b1010, 4'b1011, 4'b1100, 4'b1110, 4'b1111};
        rst          = 1'b0;
        bus.frameni  = 1'b1;
        bus.framenid = 1'b1;
        bus.ad_i     = 32'h0;
        bus.cbe_ni   = 4'hF;
        bus.idseli   = 1'b0;
        bus.bar_base = 8'h12;
        bus.mem_en   = 1'b1;
        bus.inc_adr  = 1'b0;
        bus.acc_end  = 1'b0;
        go(1'b1, 1'b1, 32'h0, 4'hF, 1'b0, 1'b0);
        cmp("reset_card_hit", 32'(bus.card_hit), 32'd0);
        cmp("reset_t_adr",    32'(bus.t_adr),    32'd0);
        go(1'b1, 1'b1, 32'h0, 4'hF, 1'b0, 1'b0);
        rst = 1'b1;

        // 1: memory read hit
        go(1'b0, 1'b1, 32'h1200_0010, 4'b1001, 1'b0, 1'b0);
        go(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        cmp("t1_card_hit", 32'(bus.card_hit), 32'd1);
        cmp("t1_acc_rd",   32'(bus.acc_rd),   32'd1);
        cmp("t1_acc_wr",   32'(bus.acc_wr),   32'd0);
        cmp("t1_t_adr",    32'(bus.t_adr),    32'h4);
        cmp("t1_model_adr", m.adr, 32'h4);
        go(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        go(1'b1, 1'b1, 32'h0, 4'hF, 1'b0, 1'b0);
        cmp("t1_end_card_hit", 32'(bus.card_hit), 32'd0);

        // 2: BAR mismatch, then memory space disabled
        go(1'b0, 1'b1, 32'h1300_0010, 4'b1001, 1'b0, 1'b0);
        go(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        cmp("t2_bar_card_hit", 32'(bus.card_hit), 32'd0);
        cmp("t2_bar_acc_rd",   32'(bus.acc_rd),   32'd0);
        go(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        bus.mem_en = 1'b0;
        go(1'b0, 1'b1, 32'h1200_0010, 4'b1001, 1'b0, 1'b0);
        go(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        bus.mem_en = 1'b1;
        cmp("t2_men_card_hit", 32'(bus.card_hit), 32'd0);
        cmp("t2_men_model_hit", 32'(m.hit), 32'd0);
        go(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);

        // 3: write burst to the top of the window and wrap
        go(1'b0, 1'b1, 32'h12FF_FFF8, 4'b1000, 1'b0, 1'b0);
        go(1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        cmp("t3_t_adr_fe",  32'(bus.t_adr),      32'h3FFFFE);
        cmp("t3_acc_wr",    32'(bus.acc_wr),     32'd1);
        cmp("t3_term_fe",   32'(bus.t_term_req), 32'd0);
        go(1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        cmp("t3_t_adr_ff",  32'(bus.t_adr),      32'h3FFFFF);
        cmp("t3_term_ff",   32'(bus.t_term_req), 32'd1);
        cmp("t3_model_adr_ff", m.adr, 32'h3FFFFF);
        go(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        cmp("t3_wrap_adr",  32'(bus.t_adr),      32'h0);
        go(1'b1, 1'b1, 32'h0, 4'hF, 1'b0, 1'b0);

        // 4: config read hit, then misaligned config address
        go(1'b0, 1'b1, 32'h0000_0004, 4'b0101, 1'b0, 1'b0);
        bus.idseli = 1'b1;
        go(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        cmp("t4_cfg_hit",  32'(bus.cfg_hit),    32'd1);
        cmp("t4_card_hit", 32'(bus.card_hit),   32'd1);
        cmp("t4_term",     32'(bus.t_term_req), 32'd1);
        cmp("t4_t_adr",    32'(bus.t_adr),      32'h1);
        go(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        go(1'b0, 1'b1, 32'h0000_0005, 4'b0101, 1'b0, 1'b0);
        go(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        bus.idseli = 1'b0;
        cmp("t4_mis_card_hit", 32'(bus.card_hit), 32'd0);
        cmp("t4_mis_cfg_hit",  32'(bus.cfg_hit),  32'd0);
        go(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);

        // 5: fast back-to-back, new decode wins over acc_end
        go(1'b0, 1'b1, 32'h1200_0010, 4'b1001, 1'b0, 1'b0);
        go(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        go(1'b0, 1'b1, 32'h1200_0100, 4'b1000, 1'b0, 1'b1);
        go(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        cmp("t5_card_hit", 32'(bus.card_hit), 32'd1);
        cmp("t5_acc_wr",   32'(bus.acc_wr),   32'd1);
        cmp("t5_acc_rd",   32'(bus.acc_rd),   32'd0);
        cmp("t5_t_adr",    32'(bus.t_adr),    32'h40);
        go(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        go(1'b1, 1'b1, 32'h0, 4'hF, 1'b0, 1'b0);
        cmp("t5_end_card_hit", 32'(bus.card_hit), 32'd0);
        cmp("t5_end_acc_wr",   32'(bus.acc_wr),   32'd0);

        // 6: reset mid-burst
        go(1'b0, 1'b1, 32'h1200_0000, 4'b1000, 1'b0, 1'b0);
        go(1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        go(1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        cmp("t6_pre_t_adr", 32'(bus.t_adr), 32'h1);
        rst = 1'b0;
        go(1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        rst = 1'b1;
        cmp("t6_card_hit", 32'(bus.card_hit), 32'd0);
        cmp("t6_acc_wr",   32'(bus.acc_wr),   32'd0);
        cmp("t6_t_adr",    32'(bus.t_adr),    32'd0);
        cmp("t6_t_cmd",    32'(bus.t_cmd),    32'd0);
        go(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        go(1'b1, 1'b1, 32'h0, 4'hF, 1'b0, 1'b0);

        // Random address phases, bursts, access ends and resets
        prev_fn = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (prev_fn) r_fn = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            else         r_fn = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            r_ad = $urandom;
            if ($urandom_range(0, 3) != 0) r_ad[31:24] = bus.bar_base;
            if ($urandom_range(0, 3) == 0) r_ad[23:2] = 22'h3FFFFF - 22'($urandom_range(0, 2));
            if ($urandom_range(0, 2) != 0) r_ad[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) r_cbe = ~vcmd[$urandom_range(0, 6)];
            else                           r_cbe = 4'($urandom_range(0, 15));
            go(r_fn, prev_fn, r_ad, r_cbe, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0);
            prev_fn    = r_fn;
            rst        = ($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0;
            bus.idseli = 1'($urandom_range(0, 1));
            bus.mem_en = ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 199) == 0) bus.bar_base = 8'($urandom_range(8'h11, 8'h13));
        end

        go(1'b1, 1'b1, 32'h0, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
